// File: rtl/bitblade_pkg.sv
// bitblade_pkg: shared precision codes, sequencer state encoding and config helpers
package bitblade_pkg;

    localparam logic [1:0] PREC_2B  = 2'b00;
    localparam logic [1:0] PREC_4B  = 2'b01;
    localparam logic [1:0] PREC_8B  = 2'b10;
    localparam logic [1:0] PREC_ILL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic prec_legal(input logic [3:0] prec);
        return prec[3:2] != PREC_ILL && prec[1:0] != PREC_ILL;
    endfunction

endpackage

// File: rtl/bitblade_lat_cnt.sv
// bitblade_lat_cnt: loadable down-counter that flags expiry at zero
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (wins over en)
//   load_val   : value to load
//   en         : count down one step per cycle, saturating at zero
//   expire     : count is zero
module bitblade_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);

    assign expire = cnt == '0;

endmodule

// File: rtl/bitblade_seq_ctrl.sv
// bitblade_seq_ctrl: job sequencer feeding operand beats to the BitBlade PE datapath
//   cfg_*      : job config handshake (prec code, beats per group, group count), cfg_err on reject
//   in_*       : operand beat stream, accepted only in RUN
//   Precision, I_out, W_out, issue_valid, acc_clr, acc_en : registered datapath drive
//   out_valid/out_ready : per-group result handshake; done pulses on the last one
//   busy       : job in progress
module bitblade_seq_ctrl
    import bitblade_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 16,
    parameter int GRP_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_prec,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [GRP_W-1:0]  cfg_grps,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_w,
    output logic [3:0]        Precision,
    output logic [DATA_W-1:0] I_out,
    output logic [DATA_W-1:0] W_out,
    output logic              issue_valid,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int LAT_W = $clog2(PIPE_LAT + 1);

    logic [1:0]       state;
    logic [LEN_W-1:0] len, beat_cnt;
    logic [GRP_W-1:0] grps, grp_cnt;
    logic             accept, cfg_ok, last_beat, last_grp, lat_expire;

    assign cfg_ready = state == ST_IDLE;
    assign in_ready  = state == ST_RUN;
    assign busy      = state != ST_IDLE;
    assign acc_en    = issue_valid;
    assign accept    = in_valid && in_ready;
    assign cfg_ok    = prec_legal(cfg_prec) && cfg_len != '0 && cfg_grps != '0;
    assign last_beat = beat_cnt == len - LEN_W'(1);
    assign last_grp  = grp_cnt == grps - GRP_W'(1);

    // Loaded on the last accept so that, counting the issue cycle itself,
    // HOLD is entered PIPE_LAT+1 edges after that accept.
    bitblade_lat_cnt #(.W(LAT_W)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && last_beat),
        .load_val (LAT_W'(PIPE_LAT)),
        .en       (state == ST_DRAIN),
        .expire   (lat_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            Precision   <= '0;
            I_out       <= '0;
            W_out       <= '0;
            issue_valid <= 1'b0;
            acc_clr     <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            len         <= '0;
            grps        <= '0;
            beat_cnt    <= '0;
            grp_cnt     <= '0;
        end else begin
            issue_valid <= accept;
            acc_clr     <= accept && beat_cnt == '0;
            cfg_err     <= cfg_ready && cfg_valid && !cfg_ok;
            done        <= 1'b0;
            if (accept) begin
                I_out <= in_i;
                W_out <= in_w;
            end
            case (state)
                ST_IDLE:
                    if (cfg_valid && cfg_ok) begin
                        Precision <= cfg_prec;
                        len       <= cfg_len;
                        grps      <= cfg_grps;
                        beat_cnt  <= '0;
                        grp_cnt   <= '0;
                        state     <= ST_RUN;
                    end
                ST_RUN:
                    if (accept) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + LEN_W'(1);
                        state    <= last_beat ? ST_DRAIN : ST_RUN;
                    end
                ST_DRAIN:
                    if (lat_expire) begin
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                default:
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        grp_cnt   <= grp_cnt + GRP_W'(1);
                        done      <= last_grp;
                        state     <= last_grp ? ST_IDLE : ST_RUN;
                    end
            endcase
        end
    end

endmodule

// File: tb/tb_bitblade_seq_ctrl.sv
// tb_bitblade_seq_ctrl: randomized scoreboard bench for bitblade_seq_ctrl
module tb_bitblade_seq_ctrl;

    localparam int DATA_W   = 32;
    localparam int LEN_W    = 16;
    localparam int GRP_W    = 8;
    localparam int PIPE_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_prec = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [GRP_W-1:0]  cfg_grps = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_i = '0;
    logic [DATA_W-1:0] in_w = '0;
    logic [3:0]        Precision;
    logic [DATA_W-1:0] I_out, W_out;
    logic              issue_valid, acc_clr, acc_en, out_valid;
    logic              out_ready = 1'b0;
    logic              busy, done, cfg_err;

    always #5 clk = ~clk;

    bitblade_seq_ctrl #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .GRP_W(GRP_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prec(cfg_prec),
        .cfg_len(cfg_len), .cfg_grps(cfg_grps),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_w(in_w),
        .Precision(Precision), .I_out(I_out), .W_out(W_out),
        .issue_valid(issue_valid), .acc_clr(acc_clr), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    typedef struct {
        logic [DATA_W-1:0] i;
        logic [DATA_W-1:0] w;
        logic              clr;
        logic [3:0]        prec;
    } issue_t;

    typedef struct {
        int   cyc;
        logic last;
    } rise_t;

    issue_t     exp_issue[$];
    rise_t      exp_rise[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [3:0] model_prec = '0;
    logic       or_force = 1'b0;
    logic       or_rand = 1'b0;
    logic       mon_prev_ov = 1'b0;
    logic       mon_hs = 1'b0;
    logic       mon_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = or_force ? 1'b0 : or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops expected issues / group results whenever the DUT presents them.
    initial forever begin
        issue_t e;
        rise_t  r;
        @(negedge clk);
        if (!rst_n) begin
            exp_issue.delete();
            exp_rise.delete();
            mon_prev_ov = 1'b0;
            mon_hs = 1'b0;
        end else begin
            if (issue_valid) begin
                if (exp_issue.size() == 0) chk("unexpected_issue", 1, 0);
                else begin
                    e = exp_issue.pop_front();
                    chk("issue", {I_out, W_out, acc_clr, acc_en, Precision},
                        {e.i, e.w, e.clr, 1'b1, e.prec});
                end
            end
            if (mon_hs)
                chk("after_handshake", {done, in_ready, busy, out_valid},
                    {mon_last, !mon_last, !mon_last, 1'b0});
            else
                chk("no_stray_done", done, 0);
            if (out_valid && !mon_prev_ov) begin
                if (exp_rise.size() == 0) chk("unexpected_out_valid", 1, 0);
                else begin
                    r = exp_rise.pop_front();
                    chk("out_valid_latency", cyc, r.cyc);
                    mon_last = r.last;
                end
            end
            if (mon_prev_ov && !mon_hs) chk("out_valid_held", out_valid, 1);
            if (out_valid && !out_ready) chk("hold_in_ready", in_ready, 0);
            mon_hs = out_valid && out_ready;
            mon_prev_ov = out_valid;
        end
    end

    task automatic do_cfg(input logic [3:0] p, input int len, input int grps);
        cfg_valid = 1'b1;
        cfg_prec  = p;
        cfg_len   = LEN_W'(len);
        cfg_grps  = GRP_W'(grps);
        @(negedge clk);
        chk("cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        if (p[3:2] != 2'b11 && p[1:0] != 2'b11 && len != 0 && grps != 0) begin
            model_prec = p;
            chk("cfg_accept", {Precision, busy, cfg_err}, {p, 1'b1, 1'b0});
        end else begin
            chk("cfg_reject", {Precision, busy, cfg_err, cfg_ready}, {model_prec, 1'b0, 1'b1, 1'b1});
            @(posedge clk);
            #1;
            chk("cfg_err_pulse", cfg_err, 0);
        end
    endtask

    // gap: 0 none, 1 alternate idle cycle, 2 random 0..2 idle cycles
    task automatic drive_job(input int len, input int grps, input int gap, input bit busy_cfg);
        int t;
        int ng;
        for (int g = 0; g < grps; g++) begin
            for (int k = 0; k < len; k++) begin
                ng = gap == 1 ? (k > 0 ? 1 : 0) : gap == 2 ? int'($urandom_range(0, 2)) : 0;
                repeat (ng) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b1;
                in_i = $urandom;
                in_w = $urandom;
                if (busy_cfg && g == 0 && k == 0) begin
                    cfg_valid = 1'b1;
                    cfg_prec  = 4'b1010;
                    cfg_len   = 5;
                    cfg_grps  = 1;
                end
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!in_ready && t < 300);
                if (!in_ready) begin
                    chk("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    cfg_valid = 1'b0;
                    return;
                end
                exp_issue.push_back('{in_i, in_w, k == 0, model_prec});
                if (k == len - 1) exp_rise.push_back('{cyc + PIPE_LAT + 2, g == grps - 1});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                if (cfg_valid) begin
                    cfg_valid = 1'b0;
                    chk("busy_cfg_ignored", {cfg_err, Precision, busy}, {1'b0, model_prec, 1'b1});
                end
            end
        end
        t = 0;
        while (busy && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("job_done", {busy, cfg_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic [3:0] p;
        int len;
        int grps;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {Precision, I_out, W_out, issue_valid, acc_clr, acc_en, out_valid, done, cfg_err, busy, in_ready, cfg_ready},
            {4'b0, 32'b0, 32'b0, 9'b0, 1'b1});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {busy, cfg_ready, in_ready}, {1'b0, 1'b1, 1'b0});

        do_cfg(4'b1101, 3, 2);
        do_cfg(4'b0000, 0, 2);
        do_cfg(4'b0000, 3, 0);

        do_cfg(4'b0100, 3, 2);
        drive_job(3, 2, 0, 0);

        do_cfg(4'b0001, 4, 2);
        fork
            drive_job(4, 2, 1, 0);
            begin
                or_force = 1'b1;
                t = 0;
                while (!out_valid && t < 300) begin
                    @(posedge clk);
                    t++;
                end
                repeat (5) @(posedge clk);
                or_force = 1'b0;
            end
        join

        do_cfg(4'b1000, 1, 3);
        drive_job(1, 3, 0, 0);

        do_cfg(4'b0110, 3, 1);
        drive_job(3, 1, 0, 1);

        do_cfg(4'b0010, 2, 1);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_i = $urandom;
            in_w = $urandom;
            @(negedge clk);
            chk("rst_test_in_ready", in_ready, 1);
            exp_issue.push_back('{in_i, in_w, k == 0, model_prec});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {Precision, I_out, W_out, issue_valid, acc_clr, acc_en, out_valid, done, cfg_err, busy, in_ready, cfg_ready},
            {4'b0, 32'b0, 32'b0, 9'b0, 1'b1});
        model_prec = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cfg_ready_after_reset", {cfg_ready, busy}, {1'b1, 1'b0});
        do_cfg(4'b1001, 2, 2);
        drive_job(2, 2, 0, 0);

        do_cfg(4'b1010, 1, 255);
        drive_job(1, 255, 0, 0);

        or_rand = 1'b1;
        repeat (12) begin
            p = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            len = $urandom_range(1, 6);
            grps = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) do_cfg(p | 4'b0011, len, grps);
            do_cfg(p, len, grps);
            drive_job(len, grps, 2, 0);
        end
        or_rand = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_issue.size() + exp_rise.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
